// File: rtl/serial_adder_pkg.sv
// Shared state encoding and default width for the bit-serial adder.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned SA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT,
    StDone  = ST_DONE
  } sa_state_e;

endpackage

// File: rtl/fa_bit.sv
// Combinational single-bit full adder cell.
module fa_bit (
  input  logic Ain,
  input  logic Bin,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = Ain ^ Bin ^ Cin;
  assign Cout = (Ain & Bin) | (Cin & (Ain ^ Bin));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per clock.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_out_q, sum_out_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             cell_sum, cell_cout;

  fa_bit u_fa_bit (
    .Ain  (a_sr_q[0]),
    .Bin  (b_sr_q[0]),
    .Cin  (carry_q),
    .Sum  (cell_sum),
    .Cout (cell_cout)
  );

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    sum_sr_d  = sum_sr_q;
    sum_out_d = sum_out_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d   = a_in;
          b_sr_d   = b_in;
          carry_d  = cin_in;
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {cell_sum, sum_sr_q[WIDTH-1:1]};
        carry_d  = cell_cout;
        if (cnt_q == CntLast) begin
          // Last bit: publish result; counter left at its final value so it never wraps.
          sum_out_d = {cell_sum, sum_sr_q[WIDTH-1:1]};
          cout_d    = cell_cout;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      sum_sr_q  <= '0;
      sum_out_q <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      sum_sr_q  <= sum_sr_d;
      sum_out_q <= sum_out_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign sum_out  = sum_out_q;
  assign cout_out = cout_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder that sits directly upstream of the single-bit full-adder cell and drives it one bit per clock. It accepts two WIDTH-bit operands plus carry-in on a start strobe. It feeds LSB-first bit pairs and the registered carry into the cell, collects the cell's sum/carry outputs, and presents the assembled WIDTH-bit sum and final carry with a done pulse. It trades WIDTH cycles of latency for a single full-adder instance.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32

- clk  in  1  single rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a_in  in  WIDTH  operand A; captured on accepted start
- b_in  in  WIDTH  operand B; captured on accepted start
- cin_in  in  1  carry-in; captured on accepted start
- busy  out  1  high from the edge after start acceptance until return to IDLE
- done  out  1  one-cycle pulse; result valid
- sum_out  out  WIDTH  registered result, (a+b+cin) mod 2^WIDTH
- cout_out  out  1  registered carry-out of bit WIDTH-1

## Operation
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, sum_out=0, cout_out=0, operand shift registers=0, carry reg=0, bit counter=0.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at an edge loads a_sr<=a_in, b_sr<=b_in, carry<=cin_in, cnt<=0, sum_sr<=0. The state then goes to SHIFT. start=0 keeps the block in IDLE.
- SHIFT: the cell sees Ain=a_sr[0], Bin=b_sr[0], Cin=carry. Each edge does the following:
  - a_sr and b_sr shift right by 1, zero-filled.
  - sum_sr <= {cell_sum, sum_sr[WIDTH-1:1]}.
  - carry <= cell_cout.
  - cnt <= cnt+1.
- When cnt==WIDTH-1 at an edge, the last bit is processed. On that edge sum_out <= {cell_sum, sum_sr[WIDTH-1:1]}, cout_out <= cell_cout, state goes to DONE, and done=1.
- DONE: the state goes to IDLE on the next edge and done returns to 0.
- start is ignored in SHIFT and DONE. It is not queued.
- sum_out and cout_out change only on entry to DONE (or reset). They hold the last result during a later operation, until that operation's DONE.
- Arithmetic: pure binary unsigned. The final carry is cout_out; there is no overflow flag.
- Counter width: $clog2(WIDTH). The count never wraps within an operation.

## Timing
- Start sampled at edge E0: busy=1 after E0. The SHIFT edges are E1..EWIDTH.
- After edge EWIDTH: done=1, result valid, busy stays 1.
- After edge EWIDTH+1: state=IDLE, busy=0, done=0.
- Earliest next accepted start is at edge EWIDTH+2, so the issue interval is WIDTH+2 cycles.
- Operand inputs only need to be stable at E0.
- Reset mid-operation aborts immediately. All outputs go to reset values, and no done is produced for the aborted operation.
- Reset release takes effect at the first edge with rst_n=1. start may be accepted at that edge.

## Structure
- Package serial_adder_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - the default width constant SA_WIDTH_DEF=8.
- Sub-module fa_bit: a combinational single-bit full adder (Ain, Bin, Cin -> Sum, Cout). It is instantiated once, and the same cell type is used as elsewhere in the design.
- Top module holds the FSM, the bit counter, the a/b/sum shift registers, the carry flop, and the output registers.

## Test plan
- WIDTH=8, a=0x0F, b=0x01, cin=0, start one cycle -> done pulses exactly 8 edges after the start edge; sum_out=0x10, cout_out=0; busy high for 9 cycles.
- a=0xFF, b=0x01, cin=0 -> sum_out=0x00, cout_out=1. Then a=0xA5, b=0x5A, cin=1 -> sum_out=0x00, cout_out=1.
- a=0x3C, b=0x42, cin=1 -> sum_out=0x7F, cout_out=0. sum_out holds the previous result (0x00) until this operation's done.
- start held high continuously with changing operands -> only operands present at IDLE edges are accepted; the issue interval is exactly 10 cycles; starts during SHIFT/DONE are ignored.
- Assert rst_n=0 mid-SHIFT (after 4 bits) -> busy, done, sum_out and cout_out go to 0 immediately, with no done. After release, a new start with a=0x80, b=0x80, cin=0 gives sum_out=0x00, cout_out=1.
- Randomised sweep, 200 operations at WIDTH=8 and WIDTH=16: sum_out and cout_out match a reference model of a+b+cin on every done.
